arb_req_agent: RTL

//  Requester-side agent for the fixed-priority arbiter. It buffers outgoing

---
 rtl/arb_req_agent_if.sv | 30 +++
 rtl/arb_req_agent.sv | 130 +++++++++++++
 2 files changed

// File: rtl/arb_req_agent_if.sv
// arb_req_agent_if: local source, arbiter req/gnt and shared bus signals.
// master = agent side, slave = source/arbiter/bus side.
interface arb_req_agent_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          req;
  logic          gnt;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic          bus_last;
  logic          bus_ready;

  modport master (
    input  in_valid, in_data, in_last,
    input  gnt, bus_ready,
    output in_ready, req,
    output bus_valid, bus_data, bus_last
  );

  modport slave (
    output in_valid, in_data, in_last,
    output gnt, bus_ready,
    input  in_ready, req,
    input  bus_valid, bus_data, bus_last
  );
endinterface

// File: rtl/arb_req_agent.sv
// arb_req_agent: buffers packets in a FIFO, requests the arbiter once a
// whole packet is held, streams exactly one packet per grant.
// Ports: clk, rstn (async low), bif (in_*, req/gnt, bus_*),
//        busy, tmo_err (sticky REQ timeout), pkt_err (sticky oversize pkt).
module arb_req_agent #(
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rstn,
  arb_req_agent_if.master bif,
  output logic            busy,
  output logic            tmo_err,
  output logic            pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BACKOFF,
    XFER
  } state_t;

  state_t        state_q, state_d;
  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, pkt_cnt;
  logic [WW-1:0] wait_cnt, wait_d;
  logic          req_q, tmo_set;
  logic          full, empty;
  logic          push, pop;
  logic          head_last, bus_vld;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = bif.in_valid && !full;
  assign head_last = mem[rd_ptr][DW];
  assign bus_vld   = (state_q == XFER) && !empty;
  assign pop       = bus_vld && bif.bus_ready;

  assign bif.in_ready  = !full;
  assign bif.req       = req_q;
  assign bif.bus_valid = bus_vld;
  assign bif.bus_data  = mem[rd_ptr][DW-1:0];
  assign bif.bus_last  = head_last;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bif.in_last, bif.in_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // count of complete packets sitting in the FIFO
      case ({push && bif.in_last, pop && head_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pkt_cnt != '0) state_d = REQ;
      end
      REQ: begin
        if (bif.gnt) begin
          state_d = XFER;
          wait_d  = '0;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          state_d = BACKOFF;
          wait_d  = '0;
          tmo_set = 1'b1;
        end else begin
          wait_d = wait_cnt + WW'(1);
        end
      end
      BACKOFF: begin
        state_d = REQ;
        wait_d  = '0;
      end
      XFER: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      req_q    <= 1'b0;
      tmo_err  <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      req_q    <= (state_d == REQ);
      tmo_err  <= tmo_err | tmo_set;
      // full with no packet boundary: the packet can never complete
      pkt_err  <= pkt_err | (full && (pkt_cnt == '0));
    end
  end

endmodule
